// File: rtl/pwm_phase_controller.sv
// rtl/pwm_phase_controller.sv - two-leg PWM sequencer with duty double-buffer and dead time
module pwm_phase_controller #(
  parameter int WIDTH_TRIANG = 7,
  parameter int DT_W         = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    fault,
  input  logic [WIDTH_TRIANG-1:0] carrier_0,
  input  logic [WIDTH_TRIANG-1:0] carrier_180,
  input  logic [WIDTH_TRIANG-1:0] duty_in,
  input  logic                    duty_we,
  input  logic [DT_W-1:0]         dt_cycles,
  output logic                    gate_a_hi,
  output logic                    gate_a_lo,
  output logic                    gate_b_hi,
  output logic                    gate_b_lo,
  output logic [WIDTH_TRIANG-1:0] duty_active,
  output logic [1:0]              state,
  output logic                    sync_pulse
);

  localparam logic [WIDTH_TRIANG-1:0] MAX    = '1;
  localparam logic [DT_W-1:0]         DT_ONE = {{(DT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [WIDTH_TRIANG-1:0] r_duty_active;
  logic [WIDTH_TRIANG-1:0] r_pending;
  logic                    r_pending_valid;
  logic                    r_sync;
  logic [1:0]              r_q;
  logic [1:0]              r_hi;
  logic [1:0]              r_lo;
  logic [DT_W-1:0]         r_dtcnt [2];
  logic [1:0]              w_raw;
  logic                    w_valley;

  assign w_valley = (carrier_0 == '0);
  assign w_raw[0] = (r_duty_active == MAX) || (r_duty_active > carrier_0);
  assign w_raw[1] = (r_duty_active == MAX) || (r_duty_active > carrier_180);

  // Fault dominates every transition; FAULT only exits once en has also dropped.
  always_comb begin
    w_next = r_state;
    if (fault) begin
      w_next = S_FAULT;
    end else begin
      case (r_state)
        S_IDLE:  w_next = en ? S_ARM : S_IDLE;
        S_ARM:   w_next = !en ? S_IDLE : (w_valley ? S_RUN : S_ARM);
        S_RUN:   w_next = en ? S_RUN : S_IDLE;
        S_FAULT: w_next = en ? S_FAULT : S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_duty_active   <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      r_sync          <= 1'b0;
      r_q             <= '0;
      r_hi            <= '0;
      r_lo            <= '0;
      r_dtcnt[0]      <= '0;
      r_dtcnt[1]      <= '0;
    end else begin
      r_state <= w_next;
      r_sync  <= w_valley && (w_next == S_RUN);

      if (duty_we) begin
        r_pending <= duty_in;
      end
      // Valley commit: a same-cycle write bypasses the pending slot.
      if (w_valley) begin
        if (duty_we) begin
          r_duty_active <= duty_in;
        end else if (r_pending_valid) begin
          r_duty_active <= r_pending;
        end
        r_pending_valid <= 1'b0;
      end else if (duty_we) begin
        r_pending_valid <= 1'b1;
      end

      for (int i = 0; i < 2; i++) begin
        if (w_next != S_RUN) begin
          r_hi[i] <= 1'b0;
          r_lo[i] <= 1'b0;
        end else if ((r_state != S_RUN) || (w_raw[i] != r_q[i])) begin
          r_q[i]     <= w_raw[i];
          r_dtcnt[i] <= dt_cycles;
          r_hi[i]    <= 1'b0;
          r_lo[i]    <= 1'b0;
        end else if (r_dtcnt[i] != '0) begin
          r_dtcnt[i] <= r_dtcnt[i] - DT_ONE;
          r_hi[i]    <= 1'b0;
          r_lo[i]    <= 1'b0;
        end else begin
          r_hi[i] <= r_q[i];
          r_lo[i] <= !r_q[i];
        end
      end
    end
  end

  assign state       = r_state;
  assign duty_active = r_duty_active;
  assign sync_pulse  = r_sync;
  assign gate_a_hi   = r_hi[0];
  assign gate_a_lo   = r_lo[0];
  assign gate_b_hi   = r_hi[1];
  assign gate_b_lo   = r_lo[1];

endmodule

// File: tb/tb_pwm_phase_controller.sv
// tb/tb_pwm_phase_controller.sv - scoreboard bench for pwm_phase_controller
module tb_pwm_phase_controller;

  logic       clk = 1'b0;
  logic       rst, en, fault, duty_we;
  logic [6:0] carrier_0, carrier_180, duty_in;
  logic [3:0] dt_cycles;
  logic       gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo, sync_pulse;
  logic [6:0] duty_active;
  logic [1:0] state;

  pwm_phase_controller #(.WIDTH_TRIANG(7), .DT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .fault(fault),
    .carrier_0(carrier_0), .carrier_180(carrier_180),
    .duty_in(duty_in), .duty_we(duty_we), .dt_cycles(dt_cycles),
    .gate_a_hi(gate_a_hi), .gate_a_lo(gate_a_lo),
    .gate_b_hi(gate_b_hi), .gate_b_lo(gate_b_lo),
    .duty_active(duty_active), .state(state), .sync_pulse(sync_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic [6:0] da;
    logic [3:0] g;
    logic       sy;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   pos = 0;

  // Reference model: dead time tracked as age since the last demand change.
  int         m_state;
  logic [6:0] m_da, m_pend;
  bit         m_pv, m_sy;
  bit         m_q [2];
  bit         m_hi [2];
  bit         m_lo [2];
  int         m_age [2];
  int         m_dt [2];

  task automatic model_reset();
    m_state = 0; m_da = '0; m_pend = '0; m_pv = 0; m_sy = 0;
    for (int i = 0; i < 2; i++) begin
      m_q[i] = 0; m_hi[i] = 0; m_lo[i] = 0; m_age[i] = 0; m_dt[i] = 0;
    end
    sb_q.delete();
  endtask

  task automatic set_pos(input int p);
    pos = p % 254;
    carrier_0   = (pos <= 127) ? 7'(pos) : 7'(254 - pos);
    carrier_180 = 7'(127 - int'(carrier_0));
  endtask

  task automatic model_step();
    bit valley;
    bit raw [2];
    int nst;
    exp_t e;
    valley = (carrier_0 == 0);
    if (fault) nst = 3;
    else case (m_state)
      0: nst = en ? 1 : 0;
      1: nst = !en ? 0 : (valley ? 2 : 1);
      2: nst = en ? 2 : 0;
      default: nst = en ? 3 : 0;
    endcase
    raw[0] = (m_da == 127) || (m_da > carrier_0);
    raw[1] = (m_da == 127) || (m_da > carrier_180);
    for (int i = 0; i < 2; i++) begin
      if (nst == 2) begin
        if (m_state != 2 || raw[i] != m_q[i]) begin
          m_q[i] = raw[i]; m_age[i] = 0; m_dt[i] = int'(dt_cycles);
        end else if (m_age[i] < 1000) begin
          m_age[i]++;
        end
        m_hi[i] = m_q[i] && (m_age[i] > m_dt[i]);
        m_lo[i] = !m_q[i] && (m_age[i] > m_dt[i]);
      end else begin
        m_hi[i] = 0; m_lo[i] = 0;
      end
    end
    m_sy = valley && (nst == 2);
    if (valley) m_da = duty_we ? duty_in : (m_pv ? m_pend : m_da);
    if (duty_we) m_pend = duty_in;
    m_pv = valley ? 0 : (duty_we ? 1 : m_pv);
    m_state = nst;
    e.st = 2'(m_state); e.da = m_da; e.sy = m_sy;
    e.g  = {m_hi[0], m_lo[0], m_hi[1], m_lo[1]};
    sb_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e, got;
    model_step();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    got.st = state; got.da = duty_active; got.sy = sync_pulse;
    got.g  = {gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL scoreboard t=%0t c0=%0d got st=%0d da=%0d g=%b sy=%b exp st=%0d da=%0d g=%b sy=%b",
               $time, carrier_0, got.st, got.da, got.g, got.sy, e.st, e.da, e.g, e.sy);
    end
    duty_we = 1'b0;
    set_pos(pos + 1);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; fault = 1'b0; duty_we = 1'b0; duty_in = '0; dt_cycles = 4'd3;
    set_pos(0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo} !== 4'b0) begin failures++; $display("FAIL reset_gates got %b exp 0000", {gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo}); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (duty_active !== 7'd0) begin failures++; $display("FAIL reset_duty got %0d exp 0", duty_active); end
    checks++; if (sync_pulse !== 1'b0) begin failures++; $display("FAIL reset_sync got %b exp 0", sync_pulse); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_arm_sync();
    int arm_n, n, sync_n, first_s, last_s, low_run, gaps, bad_gaps, overlap;
    duty_in = 7'd64; duty_we = 1'b1;
    tick();
    repeat (10) tick();
    set_pos(214);
    en = 1'b1;
    arm_n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (state == 2'd1) arm_n++;
      if (state == 2'd2) break;
    end
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL arm_to_run got %0d exp 2", state); end
    checks++; if (arm_n != 40) begin failures++; $display("FAIL arm_cycles got %0d exp 40", arm_n); end
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gate_a_hi) break;
      n++;
    end
    checks++; if (n != 4) begin failures++; $display("FAIL first_gate_delay got %0d exp 4", n); end
    sync_n = 0; first_s = -1; last_s = -1; low_run = 0; gaps = 0; bad_gaps = 0; overlap = 0;
    for (int i = 0; i < 508; i++) begin
      tick();
      if (sync_pulse) begin
        sync_n++;
        if (first_s < 0) first_s = i;
        last_s = i;
      end
      if ((gate_a_hi && gate_a_lo) || (gate_b_hi && gate_b_lo)) overlap++;
      if (!gate_a_hi && !gate_a_lo) low_run++;
      else if (low_run > 0) begin
        gaps++;
        if (low_run != 4) bad_gaps++;
        low_run = 0;
      end
    end
    checks++; if (sync_n != 2) begin failures++; $display("FAIL sync_count got %0d exp 2", sync_n); end
    checks++; if (last_s - first_s != 254) begin failures++; $display("FAIL sync_period got %0d exp 254", last_s - first_s); end
    checks++; if (gaps != 4) begin failures++; $display("FAIL dead_gap_count got %0d exp 4", gaps); end
    checks++; if (bad_gaps != 0) begin failures++; $display("FAIL dead_gap_len got %0d bad exp 0", bad_gaps); end
    checks++; if (overlap != 0) begin failures++; $display("FAIL gate_overlap got %0d exp 0", overlap); end
  endtask

  task automatic test_duty_buffer();
    int stale;
    bit v;
    for (int i = 0; i < 300 && carrier_0 != 7'd90; i++) tick();
    duty_in = 7'd32; duty_we = 1'b1;
    stale = 0;
    for (int i = 0; i < 300; i++) begin
      v = (carrier_0 == 0);
      tick();
      if (v) break;
      if (duty_active !== 7'd64) stale++;
    end
    checks++; if (stale != 0) begin failures++; $display("FAIL duty_hold got %0d early changes exp 0", stale); end
    checks++; if (duty_active !== 7'd32) begin failures++; $display("FAIL duty_commit got %0d exp 32", duty_active); end
    for (int i = 0; i < 300 && carrier_0 != 7'd0; i++) tick();
    duty_in = 7'd20; duty_we = 1'b1;
    tick();
    checks++; if (duty_active !== 7'd20) begin failures++; $display("FAIL duty_bypass got %0d exp 20", duty_active); end
  endtask

  task automatic run_to_valley();
    bit v;
    for (int i = 0; i < 300; i++) begin
      v = (carrier_0 == 0);
      tick();
      if (v) break;
    end
  endtask

  task automatic test_duty_extremes();
    int bad, seen;
    duty_in = 7'd0; duty_we = 1'b1;
    tick();
    run_to_valley();
    repeat (10) tick();
    bad = 0; seen = 0;
    for (int i = 0; i < 254; i++) begin
      tick();
      if (gate_a_lo !== 1'b1) bad++;
      if (gate_a_hi) seen++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL duty0_lo got %0d low cycles exp 0", bad); end
    checks++; if (seen != 0) begin failures++; $display("FAIL duty0_hi got %0d high cycles exp 0", seen); end
    duty_in = 7'd127; duty_we = 1'b1;
    tick();
    run_to_valley();
    repeat (10) tick();
    bad = 0; seen = 0;
    for (int i = 0; i < 254; i++) begin
      tick();
      if (gate_a_hi !== 1'b1) bad++;
      if (gate_a_lo) seen++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL duty127_hi got %0d low cycles exp 0", bad); end
    checks++; if (seen != 0) begin failures++; $display("FAIL duty127_lo got %0d high cycles exp 0", seen); end
  endtask

  task automatic test_fault();
    bit v;
    fault = 1'b1;
    tick();
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL fault_state got %0d exp 3", state); end
    checks++; if ({gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo} !== 4'b0) begin failures++; $display("FAIL fault_gates got %b exp 0000", {gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo}); end
    fault = 1'b0;
    repeat (5) tick();
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL fault_latch got %0d exp 3", state); end
    en = 1'b0;
    tick();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL fault_exit got %0d exp 0", state); end
    en = 1'b1;
    v = 1'b0;
    for (int i = 0; i < 300; i++) begin
      v = (carrier_0 == 0);
      tick();
      if (state == 2'd2) break;
    end
    checks++; if (!(state === 2'd2 && v)) begin failures++; $display("FAIL resync got state %0d valley %b exp 2 1", state, v); end
    repeat (10) tick();
  endtask

  task automatic test_reset_async();
    checks++; if (gate_a_hi !== 1'b1) begin failures++; $display("FAIL pre_reset_hi got %b exp 1", gate_a_hi); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo} !== 4'b0) begin failures++; $display("FAIL async_reset_gates got %b exp 0000", {gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo}); end
    en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL post_reset_state got %0d exp 0", state); end
    checks++; if (duty_active !== 7'd0) begin failures++; $display("FAIL post_reset_duty got %0d exp 0", duty_active); end
    repeat (300) tick();
  endtask

  initial begin
    test_reset();
    test_arm_sync();
    test_duty_buffer();
    test_duty_extremes();
    test_fault();
    test_reset_async();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_phase_controller.md
Name: pwm_phase_controller

Overview:
- Sequences the two-leg PWM stage driven by the 0° and 180° triangular carriers (WIDTH_TRIANG-bit, up/down, both wrap-free).
- Compares a double-buffered duty value against each carrier and inserts programmable dead time.
- Drives complementary hi/lo gate pairs per leg.
- Owns enable/arming/fault sequencing so that gates only switch synchronised to the 0° carrier valley.

Parameters:
WIDTH_TRIANG, 7, carrier and duty width in bits; MAX = 2^WIDTH_TRIANG-1
DT_W, 4, dead-time counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  run request (level)
fault  in  1  external fault (level, highest priority)
carrier_0  in  WIDTH_TRIANG  0° triangular carrier
carrier_180  in  WIDTH_TRIANG  180° triangular carrier
duty_in  in  WIDTH_TRIANG  new duty value
duty_we  in  1  duty write strobe, one cycle
dt_cycles  in  DT_W  dead-time setting, sampled when a leg enters dead time
gate_a_hi / gate_a_lo  out  1 each  leg A gates (carrier_0)
gate_b_hi / gate_b_lo  out  1 each  leg B gates (carrier_180)
duty_active  out  WIDTH_TRIANG  duty currently used by the comparators
state  out  2  FSM state: 0 IDLE, 1 ARM, 2 RUN, 3 FAULT
sync_pulse  out  1  one-cycle marker of a 0° valley in RUN

Behaviour:
- Reset state: all gates 0, state IDLE, duty_active 0, pending duty 0/invalid, dead-time counters 0, sync_pulse 0. All outputs are registered.
- Valley = (carrier_0 == 0). It lasts exactly one cycle per carrier period (2*MAX cycles).
- Duty buffering:
  - duty_we captures duty_in into pending and sets pending_valid.
  - On a valley cycle, duty_active <= duty_in if duty_we is high that cycle (bypass), else pending if pending_valid; pending_valid is cleared.
  - duty_active never changes outside a valley. This applies in every state; the pending value is retained across states.
- FSM, evaluated each edge, fault first:
  - any state, fault=1 -> FAULT
  - IDLE: en=1 -> ARM
  - ARM: en=0 -> IDLE; valley -> RUN
  - RUN: en=0 -> IDLE
  - FAULT: fault=0 and en=0 -> IDLE; otherwise stay. fault=0 with en=1 does not restart.
- Gates are 0 in every state except RUN. On the edge that leaves RUN, all four gates go 0 on that same edge.
- Raw demand per leg:
  - A = (duty_active == MAX) | (duty_active > carrier_0)
  - B = same against carrier_180
  - duty 0 gives constant 0; duty MAX gives constant 1.
- Dead time per leg, with registered r_q and dtcnt:
  - On entry to RUN: r_q <= raw, dtcnt <= dt_cycles, both gates 0.
  - In RUN, raw != r_q: both gates 0, r_q <= raw, dtcnt <= dt_cycles (reloads even mid-dead-time).
  - In RUN, raw == r_q and dtcnt != 0: gates 0, dtcnt decrements.
  - In RUN, raw == r_q and dtcnt == 0: hi <= r_q, lo <= !r_q.
  - Result: every transition has both gates low for dt_cycles+1 cycles. hi and lo are never 1 together.
- sync_pulse is 1 on the cycle after a valley while state is RUN, else 0.
- Reset asserted mid-operation: gates 0 immediately (asynchronous), everything returns to reset values.

Test Plan:
- Reset while RUN with gate_a_hi=1 -> all gates 0 without waiting for a clock edge; state 0, duty_active 0 after release.
- en=1 at carrier_0=40 (falling) -> state 1 until carrier_0==0, then 2. First gate asserts dt_cycles+1 cycles after RUN entry; sync_pulse pulses once per 254 cycles (W=7).
- duty_we 64, dt_cycles 3 -> from the next valley, gate_a_hi high while carrier_0<64 minus a 4-cycle gap. Both leg-A gates low for exactly 4 cycles per edge; leg B mirrors this against carrier_180. gate_x_hi & gate_x_lo is never 1.
- duty_active 64; write duty 32 at carrier_0=90 -> duty_active stays 64 until the next carrier_0==0 cycle, then 32. Second check: write 20 on the valley cycle itself -> duty_active becomes 20 (bypass).
- Duty 0 -> gate_a_lo constantly 1, hi never 1. Duty 127 -> gate_a_hi constantly 1, no dead-time gap at the carrier peak.
- fault=1 in RUN -> next edge state 3, all gates 0. fault=0 with en=1 -> stays 3. en=0 -> state 0. en=1 -> ARM, re-syncs at the next valley.
